// File: rtl/memtest_pkg.sv
// Shared types, AXI constants and data pattern for the AXI memory tester.
package memtest_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE
    } state_t;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_WRITE = 2'd1;
    localparam logic [1:0] PH_READ  = 2'd2;
    localparam logic [1:0] PH_DONE  = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    function automatic logic [31:0] memtest_pattern(
        input logic [31:0] seed,
        input logic [31:0] addr
    );
        return seed ^ {addr[31:2], 2'b00};
    endfunction

    function automatic logic [1:0] phase_of(input state_t s);
        logic [1:0] ph;
        ph = PH_IDLE;
        unique case (1'b1)
            (s == S_WA), (s == S_WD), (s == S_WB): ph = PH_WRITE;
            (s == S_RA), (s == S_RD):              ph = PH_READ;
            (s == S_DONE):                         ph = PH_DONE;
            default:                               ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/axi_mem_tester_if.sv
// AXI4 master/slave channel bundle between the tester and the MIG UI port.
interface axi_mem_tester_if #(
    parameter int ADDR_W = 28
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/memtest_checker.sv
// Read-beat compare, saturating mismatch counter, optional first-error
// capture (MEMTEST_ERR_CAPTURE_EN).
module memtest_checker
    import memtest_pkg::*;
#(
    parameter int          ADDR_W = 28,
    parameter logic [31:0] SEED   = 32'h5A5A_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rdata,
    output logic              mismatch,
    output logic [15:0]       err_count
`ifdef MEMTEST_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic              first_err_valid
`endif
);
    logic [31:0] expected;

    assign expected = memtest_pattern(SEED, 32'(addr));
    assign mismatch = beat_valid && (rdata != expected);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count <= '0;
        end else if (mismatch && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

`ifdef MEMTEST_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            first_err_addr  <= '0;
            first_err_data  <= '0;
            first_err_valid <= 1'b0;
        end else if (mismatch && !first_err_valid) begin
            first_err_addr  <= addr;
            first_err_data  <= rdata;
            first_err_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 write/read-back memory tester: FSM and registered AXI channels.
// Optional first-error capture ports under MEMTEST_ERR_CAPTURE_EN.
module axi_mem_tester
    import memtest_pkg::*;
#(
    parameter int                ADDR_W     = 28,
    parameter int                DATA_W     = 32,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       SEED       = 32'h5A5A_0000
) (
    input  logic        ui_clk,
    input  logic        ui_clk_sync_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        resp_err,
    output logic [15:0] err_count,
    output logic [1:0]  phase,
`ifdef MEMTEST_ERR_CAPTURE_EN
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic              first_err_valid,
`endif
    axi_mem_tester_if.master  axi
);
    localparam int IDX_W = $clog2(NUM_BURSTS + 1);
    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN * BYTES);
    localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BURSTS - 1);

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [7:0]        beat, beat_d;
    logic [ADDR_W-1:0] baddr, baddr_d;
    logic [ADDR_W-1:0] burst, burst_d;
    logic              resp_err_d;
    logic              clr, rd_beat, mismatch;
    logic              last_beat, last_burst;

    logic              awvalid_q, wvalid_q, wlast_q, bready_q;
    logic              arvalid_q, rready_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [31:0]       wdata_q;

    assign last_beat  = (beat == LAST_BEAT);
    assign last_burst = (idx == LAST_IDX);

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        beat_d     = beat;
        baddr_d    = baddr;
        burst_d    = burst;
        resp_err_d = resp_err;
        clr        = 1'b0;
        rd_beat    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: if (start) begin
                clr        = 1'b1;
                resp_err_d = 1'b0;
                idx_d      = '0;
                burst_d    = BASE_ADDR;
                state_d    = S_WA;
            end
            S_WA: if (axi.awready) begin
                beat_d  = '0;
                baddr_d = burst;
                state_d = S_WD;
            end
            S_WD: if (axi.wready) begin
                beat_d  = beat + 8'd1;
                baddr_d = baddr + BEAT_STEP;
                if (last_beat) state_d = S_WB;
            end
            S_WB: if (axi.bvalid) begin
                if (axi.bresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
                if (last_burst) begin
                    idx_d   = '0;
                    burst_d = BASE_ADDR;
                    state_d = S_RA;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    burst_d = burst + BURST_STEP;
                    state_d = S_WA;
                end
            end
            S_RA: if (axi.arready) begin
                beat_d  = '0;
                baddr_d = burst;
                state_d = S_RD;
            end
            S_RD: if (axi.rvalid) begin
                rd_beat = 1'b1;
                if (axi.rresp != AXI_RESP_OKAY || axi.rlast != last_beat)
                    resp_err_d = 1'b1;
                beat_d  = beat + 8'd1;
                baddr_d = baddr + BEAT_STEP;
                if (last_beat) begin
                    if (last_burst) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        burst_d = burst + BURST_STEP;
                        state_d = S_RA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they change with the state.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            beat      <= '0;
            baddr     <= '0;
            burst     <= '0;
            resp_err  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            phase     <= PH_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            beat      <= beat_d;
            baddr     <= baddr_d;
            burst     <= burst_d;
            resp_err  <= resp_err_d;
            busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done      <= (state_d == S_DONE);
            pass      <= (state_d == S_DONE) && !resp_err_d &&
                         (err_count == 16'd0) && !mismatch;
            phase     <= phase_of(state_d);
            awvalid_q <= (state_d == S_WA);
            wvalid_q  <= (state_d == S_WD);
            wlast_q   <= (state_d == S_WD) && (beat_d == LAST_BEAT);
            bready_q  <= (state_d == S_WB);
            arvalid_q <= (state_d == S_RA);
            rready_q  <= (state_d == S_RD);
            if (state_d == S_WA) awaddr_q <= burst_d;
            if (state_d == S_RA) araddr_q <= burst_d;
            if (state_d == S_WD)
                wdata_q <= memtest_pattern(SEED, 32'(baddr_d));
        end
    end

    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = LAST_BEAT;
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = LAST_BEAT;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    memtest_checker #(
        .ADDR_W (ADDR_W),
        .SEED   (SEED)
    ) u_checker (
        .clk             (ui_clk),
        .rst             (ui_clk_sync_rst),
        .clr             (clr),
        .beat_valid      (rd_beat),
        .addr            (baddr),
        .rdata           (axi.rdata),
        .mismatch        (mismatch),
        .err_count       (err_count)
`ifdef MEMTEST_ERR_CAPTURE_EN
        ,
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data),
        .first_err_valid (first_err_valid)
`endif
    );

endmodule
